syst_node_db: RTL and testbench

Double-buffered, parametrised weight-stationary processing element for the systolic array; next generation of the single-weight node. It adds:
- a shadow weight register loaded over a column shift chain while the active weight keeps computing;
- a propagated swap command;
- a signed/unsigned mode;
- an optional multiplier pipeline stage;
- saturating accumulation with a sticky overflow flag.

Instances tile an R×C grid: x moves east, psum and weights move south.

---
 rtl/syst_pkg.sv | 30 +++
 rtl/syst_mac_sat.sv | 96 +++++++++
 rtl/syst_node_db.sv | 103 ++++++++++
 tb/tb_syst_node_db.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/syst_pkg.sv
// Shared types and saturation-bound helpers for the double-buffered systolic node.
package syst_pkg;

  typedef enum logic [1:0] {
    W_EMPTY  = 2'd0,
    W_SHADOW = 2'd1,
    W_ACTIVE = 2'd2,
    W_BOTH   = 2'd3
  } wstate_t;

  localparam int MAX_PS = 64;

  // Largest representable value: 0111..1 when signed, all ones when unsigned.
  function automatic logic [MAX_PS-1:0] sat_hi(input int w, input bit s);
    logic [MAX_PS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_PS; i++)
      if (i < w - int'(s)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_PS-1:0] sat_lo(input int w, input bit s);
    logic [MAX_PS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_PS; i++)
      if (s && i == w - 1) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/syst_mac_sat.sv
// Multiply-accumulate with optional product register, saturating add and overflow pulse.
module syst_mac_sat
  import syst_pkg::*;
#(
  parameter int W_WIDTH   = 8,
  parameter int X_WIDTH   = 8,
  parameter int PS_WIDTH  = 24,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 1,
  parameter int MULT_PIPE = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [X_WIDTH-1:0]  x_i,
  input  logic [W_WIDTH-1:0]  w_i,
  input  logic [PS_WIDTH-1:0] psum_i,
  output logic                valid_o,
  output logic [PS_WIDTH-1:0] psum_o,
  output logic                ovf_o
);

  localparam int STAGES = 1 + MULT_PIPE;
  localparam int PW     = W_WIDTH + X_WIDTH;
  localparam int EW     = PS_WIDTH + 1;
  localparam bit SGN    = (SIGNED != 0);
  localparam logic [PS_WIDTH-1:0] SAT_HI = PS_WIDTH'(sat_hi(PS_WIDTH, SGN));
  localparam logic [PS_WIDTH-1:0] SAT_LO = PS_WIDTH'(sat_lo(PS_WIDTH, SGN));

  logic [STAGES:0]     vld_pipe;
  logic [PW-1:0]       prod;
  logic [PW-1:0]       prod_a;
  logic [PS_WIDTH-1:0] psum_a;
  logic                vld_a;
  logic [EW-1:0]       sum;
  logic                ovf_raw;
  logic [PS_WIDTH-1:0] res;
  logic [PS_WIDTH-1:0] psum_q;

  assign vld_pipe[0] = valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  generate
    if (SIGNED != 0) begin : g_smul
      assign prod = PW'($signed(x_i)) * PW'($signed(w_i));
    end else begin : g_umul
      assign prod = PW'(x_i) * PW'(w_i);
    end

    if (MULT_PIPE != 0) begin : g_pipe
      logic [PW-1:0]       prod_q;
      logic [PS_WIDTH-1:0] pin_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          prod_q <= '0;
          pin_q  <= '0;
        end else if (valid_i) begin
          prod_q <= prod;
          pin_q  <= psum_i;
        end
      end
      assign prod_a = prod_q;
      assign psum_a = pin_q;
      assign vld_a  = vld_pipe[1];
    end else begin : g_nopipe
      assign prod_a = prod;
      assign psum_a = psum_i;
      assign vld_a  = valid_i;
    end
  endgenerate

  // One guard bit above PS_WIDTH: its disagreement with the top bit (signed) or
  // its presence (unsigned) is the overflow condition.
  always_comb begin
    sum     = {SGN & psum_a[PS_WIDTH-1], psum_a}
            + {{(EW-PW){SGN & prod_a[PW-1]}}, prod_a};
    ovf_raw = SGN ? (sum[EW-1] ^ sum[PS_WIDTH-1]) : sum[EW-1];
    res     = sum[PS_WIDTH-1:0];
    if (SATURATE != 0 && ovf_raw)
      res = (SGN && sum[EW-1]) ? SAT_LO : SAT_HI;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      psum_q <= '0;
    else if (vld_a) psum_q <= res;
  end

  assign psum_o  = psum_q;
  assign valid_o = vld_pipe[STAGES];
  assign ovf_o   = vld_a & ovf_raw;

endmodule

// File: rtl/syst_node_db.sv
// Weight-stationary PE with shadow weight chain, propagated swap and sticky overflow.
module syst_node_db
  import syst_pkg::*;
#(
  parameter int W_WIDTH   = 8,
  parameter int X_WIDTH   = 8,
  parameter int PS_WIDTH  = 24,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 1,
  parameter int MULT_PIPE = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                w_valid_i,
  input  logic [W_WIDTH-1:0]  w_i,
  output logic                w_valid_o,
  output logic [W_WIDTH-1:0]  w_o,
  input  logic                swap_i,
  output logic                swap_o,
  input  logic                valid_i,
  input  logic [X_WIDTH-1:0]  x_i,
  input  logic [PS_WIDTH-1:0] psum_i,
  output logic                valid_o,
  output logic [X_WIDTH-1:0]  x_o,
  output logic [PS_WIDTH-1:0] psum_o,
  input  logic                clr_ovf_i,
  output logic                ovf_o,
  output logic [1:0]          wstate_o
);

  generate
    if (PS_WIDTH < W_WIDTH + X_WIDTH + 1) begin : g_bad_width
      $error("syst_node_db: PS_WIDTH too small for W_WIDTH+X_WIDTH+1");
    end
  endgenerate

  wstate_t            wst_q;
  logic [W_WIDTH-1:0] shadow_q, active_q, w_o_q;
  logic [X_WIDTH-1:0] x_q;
  logic               w_vld_q, swap_q, ovf_q;
  logic               shadow_v, active_v, mac_ovf;
  logic [W_WIDTH-1:0] w_eff;

  assign shadow_v = wst_q[0];
  assign active_v = wst_q[1];
  assign w_eff    = active_v ? active_q : '0;

  // A swap commits the pre-edge shadow, so a same-cycle push lands behind it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wst_q    <= W_EMPTY;
      shadow_q <= '0;
      active_q <= '0;
      w_o_q    <= '0;
      w_vld_q  <= 1'b0;
      swap_q   <= 1'b0;
      x_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      w_vld_q <= w_valid_i;
      swap_q  <= swap_i;
      ovf_q   <= (ovf_q & ~clr_ovf_i) | mac_ovf;
      if (valid_i) x_q <= x_i;
      if (w_valid_i) begin
        shadow_q <= w_i;
        w_o_q    <= shadow_q;
      end
      if (swap_i && shadow_v) begin
        active_q <= shadow_q;
        wst_q    <= w_valid_i ? W_BOTH : W_ACTIVE;
      end else if (w_valid_i) begin
        wst_q    <= active_v ? W_BOTH : W_SHADOW;
      end
    end
  end

  syst_mac_sat #(
    .W_WIDTH  (W_WIDTH),
    .X_WIDTH  (X_WIDTH),
    .PS_WIDTH (PS_WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE),
    .MULT_PIPE(MULT_PIPE)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .x_i    (x_i),
    .w_i    (w_eff),
    .psum_i (psum_i),
    .valid_o(valid_o),
    .psum_o (psum_o),
    .ovf_o  (mac_ovf)
  );

  assign w_valid_o = w_vld_q;
  assign w_o       = w_o_q;
  assign swap_o    = swap_q;
  assign x_o       = x_q;
  assign ovf_o     = ovf_q;
  assign wstate_o  = wst_q;

endmodule

// File: tb/tb_syst_node_db.sv
// Directed bench for syst_node_db: default node, 17-bit saturating node, pipelined node.
module tb_syst_node_db;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wv, sw, v, clr;
  logic [7:0]  w, x;
  logic [23:0] ps;

  logic        a_wv, a_sw, a_v, a_ovf;
  logic [7:0]  a_wo, a_x;
  logic [23:0] a_ps;
  logic [1:0]  a_ws;

  logic        b_wv, b_sw, b_v, b_ovf;
  logic [7:0]  b_wo, b_x;
  logic [16:0] b_ps;
  logic [1:0]  b_ws;

  logic        c_wv, c_sw, c_v, c_ovf;
  logic [7:0]  c_wo, c_x;
  logic [23:0] c_ps;
  logic [1:0]  c_ws;

  syst_node_db #(.PS_WIDTH(24), .MULT_PIPE(0)) da (
    .clk_i(clk), .rst_i(rst), .w_valid_i(wv), .w_i(w), .w_valid_o(a_wv), .w_o(a_wo),
    .swap_i(sw), .swap_o(a_sw), .valid_i(v), .x_i(x), .psum_i(ps), .valid_o(a_v),
    .x_o(a_x), .psum_o(a_ps), .clr_ovf_i(clr), .ovf_o(a_ovf), .wstate_o(a_ws));

  syst_node_db #(.PS_WIDTH(17), .MULT_PIPE(0)) db (
    .clk_i(clk), .rst_i(rst), .w_valid_i(wv), .w_i(w), .w_valid_o(b_wv), .w_o(b_wo),
    .swap_i(sw), .swap_o(b_sw), .valid_i(v), .x_i(x), .psum_i(ps[16:0]), .valid_o(b_v),
    .x_o(b_x), .psum_o(b_ps), .clr_ovf_i(clr), .ovf_o(b_ovf), .wstate_o(b_ws));

  syst_node_db #(.PS_WIDTH(24), .MULT_PIPE(1)) dc (
    .clk_i(clk), .rst_i(rst), .w_valid_i(wv), .w_i(w), .w_valid_o(c_wv), .w_o(c_wo),
    .swap_i(sw), .swap_o(c_sw), .valid_i(v), .x_i(x), .psum_i(ps), .valid_o(c_v),
    .x_o(c_x), .psum_o(c_ps), .clr_ovf_i(clr), .ovf_o(c_ovf), .wstate_o(c_ws));

  typedef struct {
    logic        rst, wv;
    logic [7:0]  w;
    logic        sw, v;
    logic [7:0]  x;
    logic [23:0] ps;
    logic        clr;
    logic        evo;
    logic [23:0] eps;
    logic [7:0]  ex;
    logic [1:0]  ews;
    logic        eovf, ewv;
    logic [7:0]  ewo;
    logic        esw;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic pwv, logic [7:0] pw, logic psw, logic pv,
                              logic [7:0] px, logic [23:0] pps, logic pclr,
                              logic evo, logic [23:0] eps, logic [7:0] ex, logic [1:0] ews,
                              logic eovf, logic ewv, logic [7:0] ewo, logic esw);
    vec_t t;
    t.rst = r; t.wv = pwv; t.w = pw; t.sw = psw; t.v = pv; t.x = px; t.ps = pps; t.clr = pclr;
    t.evo = evo; t.eps = eps; t.ex = ex; t.ews = ews; t.eovf = eovf; t.ewv = ewv;
    t.ewo = ewo; t.esw = esw;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wv = 0; w = 0; sw = 0; v = 0; x = 0; ps = 0; clr = 0;
  endtask

  initial begin
    //            rst wv w      sw v  x      ps        clr | vo eps        ex     ws  ov wvo wo     so
    tbl[0]  = mk(0, 1, 8'd3,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  1, 0, 1, 8'd0,  0);
    tbl[1]  = mk(0, 0, 8'd0,  1, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  2, 0, 0, 8'd0,  1);
    tbl[2]  = mk(0, 0, 8'd0,  0, 1, 8'd5,  24'd10,   0,   1, 24'd25,    8'd5,  2, 0, 0, 8'd0,  0);
    tbl[3]  = mk(0, 0, 8'd0,  0, 0, 8'd0,  24'd0,    0,   0, 24'd25,    8'd5,  2, 0, 0, 8'd0,  0);
    tbl[4]  = mk(1, 0, 8'd0,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  0, 0, 0, 8'd0,  0);
    tbl[5]  = mk(0, 0, 8'd0,  0, 1, 8'd7,  24'd7,    0,   1, 24'd7,     8'd7,  0, 0, 0, 8'd0,  0);
    tbl[6]  = mk(0, 1, 8'd1,  0, 0, 8'd0,  24'd0,    0,   0, 24'd7,     8'd7,  1, 0, 1, 8'd0,  0);
    tbl[7]  = mk(0, 0, 8'd0,  1, 0, 8'd0,  24'd0,    0,   0, 24'd7,     8'd7,  2, 0, 0, 8'd0,  1);
    tbl[8]  = mk(0, 1, 8'd2,  0, 0, 8'd0,  24'd0,    0,   0, 24'd7,     8'd7,  3, 0, 1, 8'd1,  0);
    tbl[9]  = mk(0, 1, 8'd9,  1, 1, 8'd4,  24'd0,    0,   1, 24'd4,     8'd4,  3, 0, 1, 8'd2,  1);
    tbl[10] = mk(0, 0, 8'd0,  0, 1, 8'd4,  24'd0,    0,   1, 24'd8,     8'd4,  3, 0, 0, 8'd2,  0);
    tbl[11] = mk(0, 0, 8'd0,  1, 0, 8'd0,  24'd0,    0,   0, 24'd8,     8'd4,  2, 0, 0, 8'd2,  1);
    tbl[12] = mk(0, 0, 8'd0,  0, 1, 8'd4,  24'd0,    0,   1, 24'd36,    8'd4,  2, 0, 0, 8'd2,  0);
    tbl[13] = mk(0, 1, 8'd5,  0, 0, 8'd0,  24'd0,    0,   0, 24'd36,    8'd4,  3, 0, 1, 8'd9,  0);
    tbl[14] = mk(1, 0, 8'd0,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  0, 0, 0, 8'd0,  0);
    tbl[15] = mk(0, 1, 8'd1,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  1, 0, 1, 8'd0,  0);
    tbl[16] = mk(0, 1, 8'd2,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  1, 0, 1, 8'd1,  0);
    tbl[17] = mk(0, 1, 8'd3,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  1, 0, 1, 8'd2,  0);
    tbl[18] = mk(0, 1, 8'd4,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  1, 0, 1, 8'd3,  0);
    tbl[19] = mk(0, 0, 8'd0,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  1, 0, 0, 8'd3,  0);
    tbl[20] = mk(1, 0, 8'd0,  0, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  0, 0, 0, 8'd0,  0);
    tbl[21] = mk(0, 0, 8'd0,  1, 0, 8'd0,  24'd0,    0,   0, 24'd0,     8'd0,  0, 0, 0, 8'd0,  1);
    tbl[22] = mk(0, 0, 8'd0,  0, 1, 8'd9,  24'd3,    0,   1, 24'd3,     8'd9,  0, 0, 0, 8'd0,  0);
    tbl[23] = mk(0, 1, 8'hFE, 0, 0, 8'd0,  24'd0,    0,   0, 24'd3,     8'd9,  1, 0, 1, 8'd0,  0);
    tbl[24] = mk(0, 0, 8'd0,  1, 0, 8'd0,  24'd0,    0,   0, 24'd3,     8'd9,  2, 0, 0, 8'd0,  1);
    tbl[25] = mk(0, 0, 8'd0,  0, 1, 8'd3,  24'd1,    0,   1, 24'hFFFFFB, 8'd3, 2, 0, 0, 8'd0,  0);

    idle();
    rst = 1;
    tick();
    idle();
    chk("reset psum_o",    a_ps,  0);
    chk("reset valid_o",   a_v,   0);
    chk("reset x_o",       a_x,   0);
    chk("reset wstate_o",  a_ws,  0);
    chk("reset ovf_o",     a_ovf, 0);
    chk("reset w_valid_o", a_wv,  0);
    chk("reset w_o",       a_wo,  0);
    chk("reset swap_o",    a_sw,  0);
    chk("reset pipe valid_o", c_v, 0);

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; wv = tbl[i].wv; w = tbl[i].w; sw = tbl[i].sw;
      v = tbl[i].v; x = tbl[i].x; ps = tbl[i].ps; clr = tbl[i].clr;
      tick();
      chk($sformatf("v%0d psum_o", i),    a_ps,  tbl[i].eps);
      chk($sformatf("v%0d valid_o", i),   a_v,   tbl[i].evo);
      chk($sformatf("v%0d x_o", i),       a_x,   tbl[i].ex);
      chk($sformatf("v%0d wstate_o", i),  a_ws,  tbl[i].ews);
      chk($sformatf("v%0d ovf_o", i),     a_ovf, tbl[i].eovf);
      chk($sformatf("v%0d w_valid_o", i), a_wv,  tbl[i].ewv);
      chk($sformatf("v%0d w_o", i),       a_wo,  tbl[i].ewo);
      chk($sformatf("v%0d swap_o", i),    a_sw,  tbl[i].esw);
    end

    // 17-bit signed saturation and the sticky flag
    idle(); rst = 1; tick();
    idle(); wv = 1; w = 8'h80; tick();
    idle(); sw = 1; tick();
    idle(); v = 1; x = 8'h80; ps = 24'h0FFFF; tick();
    chk("sat hi psum_o", b_ps, 17'h0FFFF);
    chk("sat hi ovf_o",  b_ovf, 1);
    chk("sat hi valid_o", b_v, 1);
    idle(); tick();
    chk("ovf sticky", b_ovf, 1);
    idle(); clr = 1; tick();
    chk("ovf cleared", b_ovf, 0);
    idle(); v = 1; x = 8'h7F; ps = 24'h10000; clr = 1; tick();
    chk("sat lo psum_o", b_ps, 17'h10000);
    chk("set beats clear ovf_o", b_ovf, 1);
    idle(); clr = 1; tick();
    idle(); v = 1; x = 8'h01; ps = 24'h0; tick();
    chk("neg no-ovf psum_o", b_ps, 17'h1FF80);
    chk("neg no-ovf ovf_o",  b_ovf, 0);

    // MULT_PIPE=1: two-cycle latency, gaps preserved, reset flushes the pipe
    idle(); rst = 1; tick();
    idle(); wv = 1; w = 8'd3; tick();
    idle(); sw = 1; tick();
    idle(); v = 1; x = 8'd1; tick();
    chk("pipe c0 valid_o", c_v, 0);
    chk("pipe c0 x_o",     c_x, 8'd1);
    idle(); v = 1; x = 8'd2; tick();
    chk("pipe c1 valid_o", c_v, 1);
    chk("pipe c1 psum_o",  c_ps, 24'd3);
    idle(); tick();
    chk("pipe c2 valid_o", c_v, 1);
    chk("pipe c2 psum_o",  c_ps, 24'd6);
    idle(); v = 1; x = 8'd3; tick();
    chk("pipe c3 valid_o", c_v, 0);
    chk("pipe c3 psum_o",  c_ps, 24'd6);
    idle(); tick();
    chk("pipe c4 valid_o", c_v, 1);
    chk("pipe c4 psum_o",  c_ps, 24'd9);
    idle(); tick();
    chk("pipe c5 valid_o", c_v, 0);
    chk("pipe c5 psum_o",  c_ps, 24'd9);
    idle(); v = 1; x = 8'd1; tick();
    chk("pipe c6 valid_o", c_v, 0);
    idle(); rst = 1; v = 1; x = 8'd2; tick();
    chk("pipe rst valid_o", c_v, 0);
    chk("pipe rst psum_o",  c_ps, 24'd0);
    chk("pipe rst x_o",     c_x, 8'd0);
    idle(); tick();
    chk("pipe flushed valid_o", c_v, 0);
    chk("pipe flushed psum_o",  c_ps, 24'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
